// File: rtl/sword_shift_rx.sv
// sword_shift_rx: serial-to-parallel receiver for the Sword board shift links
// (seg_clk/seg_pen/seg_do, led_clk/led_pen/led_do).
// Oversamples s_clk/s_pen/s_do with SI_ClkIn, shifts one bit per serial-clock
// rise while s_pen is low and latches the word when s_pen rises.
// Ports:
//   SI_ClkIn, SI_Reset_N  system clock, async active-low reset
//   s_clk, s_pen, s_do    raw serial lines (asynchronous to SI_ClkIn)
//   data_out              last frame received with exactly WIDTH bits
//   data_valid            one-cycle pulse when data_out updates
//   frame_err             one-cycle pulse when a latch sees a bad bit count
//   bit_cnt               bits received so far in the current frame
module sword_shift_rx #(
    parameter int unsigned WIDTH = 64,
    localparam int unsigned CNT_W = $clog2(WIDTH + 2)
) (
    input  logic             SI_ClkIn,
    input  logic             SI_Reset_N,
    input  logic             s_clk,
    input  logic             s_pen,
    input  logic             s_do,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             frame_err,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic sclk_ff1, sclk_sync, sclk_hist;
    logic pen_ff1, pen_sync, pen_hist;
    logic sdo_ff1, sdo_sync;
    logic [1:0] settle;
    logic armed, armed_d;

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] dout_d;
    logic [CNT_W-1:0] cnt_d;
    logic             dv_d, fe_d;

    logic sclk_rise, pen_rise, pen_fall;

    assign sclk_rise = sclk_sync & ~sclk_hist;
    assign pen_rise  = pen_sync & ~pen_hist;
    assign pen_fall  = ~pen_sync & pen_hist;

    // A pen fall is only honoured once pen has been seen high on real
    // post-reset samples, so a frame in flight across reset is discarded.
    assign armed_d = armed | (settle[1] & pen_sync);

    // Synchronisers, history flops and settle tracking.
    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            sclk_ff1  <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_hist <= 1'b0;
            pen_ff1   <= 1'b1;
            pen_sync  <= 1'b1;
            pen_hist  <= 1'b1;
            sdo_ff1   <= 1'b0;
            sdo_sync  <= 1'b0;
            settle    <= 2'b00;
            armed     <= 1'b0;
        end else begin
            sclk_ff1  <= s_clk;
            sclk_sync <= sclk_ff1;
            sclk_hist <= sclk_sync;
            pen_ff1   <= s_pen;
            pen_sync  <= pen_ff1;
            pen_hist  <= pen_sync;
            sdo_ff1   <= s_do;
            sdo_sync  <= sdo_ff1;
            settle    <= {settle[0], 1'b1};
            armed     <= armed_d;
        end
    end

    // State register.
    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pen_fall && armed) state_d = ST_SHIFT;
            ST_SHIFT: if (pen_rise)          state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: shift/count first, then the latch decision
    // on the updated values so a same-cycle clock rise is included.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = bit_cnt;
        dout_d  = data_out;
        dv_d    = 1'b0;
        fe_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pen_fall && armed) cnt_d = '0;
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    shreg_d = {shreg_q[WIDTH-2:0], sdo_sync};
                    cnt_d   = (bit_cnt == CNT_SAT) ? bit_cnt : bit_cnt + CNT_W'(1);
                end
                if (pen_rise) begin
                    if (cnt_d == CNT_FULL) begin
                        dout_d = shreg_d;
                        dv_d   = 1'b1;
                    end else begin
                        fe_d   = 1'b1;
                    end
                    cnt_d = '0;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Registered datapath and outputs.
    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            shreg_q    <= '0;
            data_out   <= '0;
            bit_cnt    <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            data_out   <= dout_d;
            bit_cnt    <= cnt_d;
            data_valid <= dv_d;
            frame_err  <= fe_d;
        end
    end

endmodule

// File: tb/tb_sword_shift_rx.sv
// Directed bench for sword_shift_rx: a WIDTH=64 and a WIDTH=16 instance share
// the serial lines; each scenario checks the instance it targets.
module tb_sword_shift_rx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_clk = 1'b0;
    logic s_pen = 1'b1;
    logic s_do = 1'b0;

    logic [63:0] dout64;
    logic        dv64, fe64;
    logic [6:0]  cnt64;
    logic [15:0] dout16;
    logic        dv16, fe16;
    logic [4:0]  cnt16;

    int checks = 0;
    int failures = 0;
    int n_dv64 = 0, n_fe64 = 0, n_dv16 = 0, n_fe16 = 0;

    always #5 clk = ~clk;

    sword_shift_rx #(.WIDTH(64)) u_dut64 (
        .SI_ClkIn(clk), .SI_Reset_N(rst_n), .s_clk(s_clk), .s_pen(s_pen), .s_do(s_do),
        .data_out(dout64), .data_valid(dv64), .frame_err(fe64), .bit_cnt(cnt64)
    );

    sword_shift_rx #(.WIDTH(16)) u_dut16 (
        .SI_ClkIn(clk), .SI_Reset_N(rst_n), .s_clk(s_clk), .s_pen(s_pen), .s_do(s_do),
        .data_out(dout16), .data_valid(dv16), .frame_err(fe16), .bit_cnt(cnt16)
    );

    // Pulse counters; scenarios compare deltas.
    always @(posedge clk) begin
        if (dv64) n_dv64 <= n_dv64 + 1;
        if (fe64) n_fe64 <= n_fe64 + 1;
        if (dv16) n_dv16 <= n_dv16 + 1;
        if (fe16) n_fe16 <= n_fe16 + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One serial bit: 4-cycle low phase with data set up, 4-cycle high phase.
    // With with_pen the pen rises on the same cycle as the clock.
    task automatic send_bit(input logic b, input logic with_pen);
        s_do = b;
        tick(4);
        s_clk = 1'b1;
        if (with_pen) s_pen = 1'b1;
        tick(4);
        s_clk = 1'b0;
    endtask

    // Shift the low nbits of val MSB first with pen low; pen left low.
    task automatic shift_bits(input logic [63:0] val, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) send_bit(val[i], 1'b0);
    endtask

    task automatic open_frame();
        s_pen = 1'b1;
        tick(4);
        s_pen = 1'b0;
        tick(4);
    endtask

    // Full frame ending with the pen rise at a falling clock edge.
    task automatic run_frame(input logic [63:0] val, input int nbits);
        open_frame();
        shift_bits(val, nbits);
        tick(2);
        s_pen = 1'b1;
    endtask

    int b_dv64, b_fe64, b_dv16, b_fe16;

    task automatic snap();
        b_dv64 = n_dv64; b_fe64 = n_fe64; b_dv16 = n_dv16; b_fe16 = n_fe16;
    endtask

    initial begin
        // Reset with pen high.
        tick(5);
        rst_n = 1'b1;
        tick(1);
        chk("rst_dout64", dout64, 64'h0);
        chk("rst_cnt64", 64'(cnt64), 64'd0);
        chk("rst_pulses64", 64'({dv64, fe64}), 64'd0);
        chk("rst_dout16", 64'(dout16), 64'h0);
        tick(4);

        // Good 64-bit frame, latency of the valid pulse.
        snap();
        open_frame();
        shift_bits(64'hDEADBEEF_01234567, 64);
        tick(4);
        chk("cnt64_full", 64'(cnt64), 64'd64);
        chk("cnt16_sat", 64'(cnt16), 64'd17);
        s_pen = 1'b1;
        tick(2);
        chk("dv64_early", 64'(dv64), 64'd0);
        tick(1);
        chk("dv64_edge3", 64'(dv64), 64'd1);
        chk("dout64_good", dout64, 64'hDEADBEEF_01234567);
        tick(1);
        chk("dv64_one_cycle", 64'(dv64), 64'd0);
        tick(4);
        chk("dv64_count", 64'(n_dv64 - b_dv64), 64'd1);
        chk("fe64_count", 64'(n_fe64 - b_fe64), 64'd0);
        chk("cnt64_clear", 64'(cnt64), 64'd0);
        chk("fe16_overrun64", 64'(n_fe16 - b_fe16), 64'd1);
        chk("dout16_kept0", 64'(dout16), 64'h0);

        // Good 16-bit frame 0xA5C3.
        snap();
        run_frame(64'hA5C3, 16);
        tick(8);
        chk("dout16_a5c3", 64'(dout16), 64'hA5C3);
        chk("dv16_a5c3", 64'(n_dv16 - b_dv16), 64'd1);
        chk("fe64_short", 64'(n_fe64 - b_fe64), 64'd1);
        chk("dout64_kept", dout64, 64'hDEADBEEF_01234567);

        // 15-bit short frame.
        snap();
        run_frame(64'h1111, 15);
        tick(8);
        chk("fe16_short", 64'(n_fe16 - b_fe16), 64'd1);
        chk("dv16_short", 64'(n_dv16 - b_dv16), 64'd0);
        chk("dout16_short_kept", 64'(dout16), 64'hA5C3);

        // 18-bit long frame 0b11_0000_1111_0000_1111.
        snap();
        open_frame();
        shift_bits(64'h30F0F, 18);
        tick(4);
        chk("cnt16_overrun", 64'(cnt16), 64'd17);
        s_pen = 1'b1;
        tick(8);
        chk("fe16_long", 64'(n_fe16 - b_fe16), 64'd1);
        chk("dv16_long", 64'(n_dv16 - b_dv16), 64'd0);
        chk("dout16_long_kept", 64'(dout16), 64'hA5C3);
        chk("cnt16_clear", 64'(cnt16), 64'd0);

        // Serial-clock edges while idle are ignored.
        snap();
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
        tick(4);
        chk("cnt16_idle", 64'(cnt16), 64'd0);
        chk("pulses_idle", 64'((n_dv16 - b_dv16) + (n_fe16 - b_fe16)), 64'd0);
        run_frame(64'h1234, 16);
        tick(8);
        chk("dout16_1234", 64'(dout16), 64'h1234);
        chk("dv16_1234", 64'(n_dv16 - b_dv16), 64'd1);

        // Clock and pen rise together on the 16th bit.
        snap();
        open_frame();
        shift_bits(64'h4000, 15);
        send_bit(1'b1, 1'b1);
        tick(8);
        chk("dout16_simul", 64'(dout16), 64'h8001);
        chk("dv16_simul", 64'(n_dv16 - b_dv16), 64'd1);
        chk("fe16_simul", 64'(n_fe16 - b_fe16), 64'd0);

        // Reset after 8 of 16 bits, then a clean frame.
        open_frame();
        shift_bits(64'hFF, 8);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("dout16_midrst", 64'(dout16), 64'h0);
        chk("cnt16_midrst", 64'(cnt16), 64'd0);
        tick(3);
        snap();
        run_frame(64'hBEEF, 16);
        tick(8);
        chk("dout16_beef", 64'(dout16), 64'hBEEF);
        chk("dv16_beef", 64'(n_dv16 - b_dv16), 64'd1);
        chk("fe16_beef", 64'(n_fe16 - b_fe16), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sword_shift_rx.md
# sword_shift_rx

Serial-to-parallel receiver for the Sword board's three-wire shift interface (clock, latch-enable, data), i.e. the far end of the `seg_clk/seg_pen/seg_do` and `led_clk/led_pen/led_do` links. It oversamples the three lines with the system clock, shifts in one bit per serial-clock rising edge, and presents a latched parallel word when the latch-enable rises. It is used as a board-model and loopback checker in simulation and as a readback monitor inside `mipsfpga_sys`.

## Interface

- `WIDTH`, 64, frame length in bits: 64 for the 8-digit 7-segment chain, 16 for the LED chain.
- `SI_ClkIn`, in, 1, system clock; the 50 MHz domain.
- `SI_Reset_N`, in, 1, asynchronous active-low reset.
- `s_clk`, in, 1, serial shift clock; asynchronous to `SI_ClkIn`.
- `s_pen`, in, 1, latch-enable; a frame is shifted while this is low and latched on its rise.
- `s_do`, in, 1, serial data, MSB first.
- `data_out`, out, WIDTH, last correctly received frame.
- `data_valid`, out, 1, one-cycle pulse when `data_out` updates.
- `frame_err`, out, 1, one-cycle pulse when a latch sees a bit count other than WIDTH.
- `bit_cnt`, out, $clog2(WIDTH+2), bits received in the current frame.

## Operation

- **Synchronisers.** `s_clk`, `s_pen` and `s_do` each pass through a 2-flop synchroniser, followed by one history flop on `s_clk` and `s_pen`. The data value used is the synchronised `s_do` from the same stage as the synchronised `s_clk`.
- **Edge detection.**
  - Rise = sync stage high and history flop low.
  - Fall = sync stage low and history flop high.
- **State machine, IDLE ↔ SHIFT.**
  - IDLE: pen is high. Serial-clock rises are ignored and nothing is counted.
  - IDLE → SHIFT on pen fall. `bit_cnt` is cleared to 0.
  - SHIFT: each serial-clock rise performs `shreg <= {shreg[WIDTH-2:0], sdo_sync}`. `bit_cnt` increments and saturates at WIDTH+1.
  - SHIFT → IDLE on pen rise.
    - If `bit_cnt == WIDTH`: load `data_out <= shreg` and pulse `data_valid`.
    - Otherwise: `data_out` is unchanged and `frame_err` pulses.
    - In both cases `bit_cnt` clears to 0.
- **Bit order.** The first bit shifted in a frame ends up in `data_out[WIDTH-1]`.
- **Overrun.** With more than WIDTH bits, `shreg` holds the last WIDTH bits, `bit_cnt` sits at WIDTH+1, and the latch reports `frame_err`.
- **Same-cycle serial-clock rise and pen rise.** The shift and count update are applied first. The latch decision uses the post-increment count, and the latched word includes the new bit.
- **Same-cycle serial-clock rise and pen fall.** The clear takes priority; the edge is not counted.
- **`data_valid` and `frame_err`** are mutually exclusive and never assert two cycles in a row.
- **Reset**, asynchronous, valid at any point including mid-frame, clears all of the following:
  - synchronisers and history flops to 0, except the pen sync and history flops, which reset to 1 so the block comes up in IDLE;
  - `shreg` and `data_out` to 0;
  - `bit_cnt` to 0;
  - `data_valid` and `frame_err` to 0;
  - the state to IDLE.
- **Frame in flight at reset release.** It is discarded. The next pen fall starts a clean frame.

## Timing

- **Minimum line timing.**
  - `s_clk` high and low phases: at least 3 `SI_ClkIn` cycles each.
  - `s_do` stable from 3 cycles before to 1 cycle after each `s_clk` rise.
  - `s_pen` low: at least 3 cycles.
  - Shorter pulses may be missed; behaviour is then undefined but never hangs, because the next pen fall recovers.
- **Latency.** Pen rise at the pin to `data_valid` or `frame_err` high is 3 `SI_ClkIn` rising edges (2 sync + 1 registered output). `data_out` changes on the same edge `data_valid` asserts.
- **`bit_cnt`** updates 3 edges after the corresponding pin edge.
- **Throughput.** One frame per `(6·WIDTH + 6)` cycles minimum.

## Test plan

- **Reset.** Assert `SI_Reset_N`=0 for 5 cycles with `s_pen`=1 → `data_out`=0, `bit_cnt`=0, no pulses; state IDLE.
- **Good frame, default WIDTH.** `WIDTH`=64, shift 0xDEADBEEF_01234567 MSB first with 4-cycle clock phases, then raise pen → exactly one `data_valid` pulse 3 cycles after the pen rise, `data_out`=0xDEADBEEF_01234567, `bit_cnt` back to 0.
- **Short and long frames.** `WIDTH`=16:
  - 15 bits then pen rise → `frame_err` pulse, `data_out` keeps its previous value 0xA5C3.
  - 18 bits 0b11_0000_1111_0000_1111 → `frame_err`, `data_out` unchanged.
- **Edges while IDLE.** Toggle `s_clk` 10 times with pen high, then send a good 16-bit frame 0x1234 → `data_out`=0x1234, `data_valid` once.
- **Simultaneous edges.** Pin-level `s_clk` and `s_pen` rise in the same cycle on the 16th bit → treated as the 16th bit; `data_valid`, `data_out` includes that bit.
- **Reset mid-frame.** Pulse reset after 8 of 16 bits, then send a full frame 0xBEEF → `data_out`=0xBEEF, no `frame_err`.
